// File: rtl/div16_8_2bits_seq.sv
// Sequential 16/8 unsigned divider retiring two quotient bits per cycle.
// Divide-by-zero and quotient overflow are flagged in one edge without iterating.
module div16_8_2bits_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] P,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Q,
  output logic [7:0]  R,
  output logic        dbz,
  output logic        ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [8:0] rem_q, rem_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] b_q, b_d;
  logic [1:0] cnt_q, cnt_d;
  logic       dbz_q, dbz_d;
  logic       ovf_q, ovf_d;

  logic       accept;
  logic [8:0] t1, t2, r1, r2;
  logic       q1, q2;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  // Two cascaded restoring steps. A set bit 8 in the incoming remainder means
  // the shifted value already exceeds any 8-bit divisor.
  always_comb begin
    t1 = {rem_q[7:0], sh_q[7]};
    q1 = rem_q[8] | (t1 >= {1'b0, b_q});
    r1 = q1 ? (t1 - {1'b0, b_q}) : t1;
    t2 = {r1[7:0], sh_q[6]};
    q2 = r1[8] | (t2 >= {1'b0, b_q});
    r2 = q2 ? (t2 - {1'b0, b_q}) : t2;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          b_d   = B;
          cnt_d = 2'd0;
          if (B == 8'd0) begin
            state_d = S_DONE;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            sh_d    = 8'hFF;
            rem_d   = 9'd0;
          end else if (P[15:8] >= B) begin
            state_d = S_DONE;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            sh_d    = 8'hFF;
            rem_d   = 9'd0;
          end else begin
            state_d = S_BUSY;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            sh_d    = P[7:0];
            rem_d   = {1'b0, P[15:8]};
          end
        end
      end
      S_BUSY: begin
        // Dividend bits leave at the top while quotient bits enter at the bottom.
        rem_d = r2;
        sh_d  = {sh_q[5:0], q1, q2};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= 9'd0;
      sh_q    <= 8'd0;
      b_q     <= 8'd0;
      cnt_q   <= 2'd0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q   = sh_q;
  assign R   = rem_q[7:0];
  assign dbz = dbz_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_div16_8_2bits_seq.sv
// Self-checking bench for div16_8_2bits_seq: directed corner cases, backpressure,
// mid-operation reset and randomized requests against an arithmetic reference.
module tb_div16_8_2bits_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] P;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Q, R;
  logic        dbz, ovf;

  int nvec = 0;
  int nerr = 0;

  div16_8_2bits_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division with the two special cases.
  task automatic ref_model(input logic [15:0] p, input logic [7:0] b,
                           output logic [7:0] eq, output logic [7:0] er,
                           output logic edbz, output logic eovf, output int elat);
    int ip, ib;
    ip = p; ib = b;
    if (ib == 0) begin
      eq = 8'hFF; er = 8'h00; edbz = 1'b1; eovf = 1'b0; elat = 1;
    end else if (ip / ib > 255) begin
      eq = 8'hFF; er = 8'h00; edbz = 1'b0; eovf = 1'b1; elat = 1;
    end else begin
      eq = 8'(ip / ib); er = 8'(ip % ib); edbz = 1'b0; eovf = 1'b0; elat = 5;
    end
  endtask

  // Issues one request, scrambles inputs while busy, holds the result for
  // 'hold' cycles with out_ready low, then consumes it.
  task automatic run_req(input logic [15:0] p, input logic [7:0] b, input int hold,
                         input bit scramble, input string tag);
    logic [7:0] eq, er;
    logic       edbz, eovf;
    int         elat, lat;
    ref_model(p, b, eq, er, edbz, eovf, elat);
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL %s in_ready before accept: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; P = p; B = b; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    if (scramble) begin
      in_valid = 1'($urandom); P = 16'($urandom); B = 8'($urandom); out_ready = 1'($urandom);
    end
    while (!out_valid && lat < 20) begin
      nvec++;
      if (in_ready !== 1'b0) begin
        nerr++; $display("FAIL %s in_ready while busy: got %b want 0", tag, in_ready);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (scramble) begin
        in_valid = 1'($urandom); P = 16'($urandom); B = 8'($urandom); out_ready = 1'($urandom);
      end
    end
    out_ready = 1'b0;
    nvec++;
    if (lat !== elat) begin
      nerr++; $display("FAIL %s latency: got %0d want %0d (p=%h b=%h)", tag, lat, elat, p, b);
    end
    nvec++;
    if (Q !== eq || R !== er || dbz !== edbz || ovf !== eovf) begin
      nerr++;
      $display("FAIL %s result p=%h b=%h: got Q=%h R=%h dbz=%b ovf=%b want Q=%h R=%h dbz=%b ovf=%b",
               tag, p, b, Q, R, dbz, ovf, eq, er, edbz, eovf);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (scramble) begin
        in_valid = 1'($urandom); P = 16'($urandom); B = 8'($urandom);
      end
      nvec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Q !== eq || R !== er ||
          dbz !== edbz || ovf !== eovf) begin
        nerr++;
        $display("FAIL %s hold cycle %0d: got ov=%b ir=%b Q=%h R=%h dbz=%b ovf=%b want ov=1 ir=0 Q=%h R=%h dbz=%b ovf=%b",
                 tag, i, out_valid, in_ready, Q, R, dbz, ovf, eq, er, edbz, eovf);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL %s consume: got ov=%b ir=%b want ov=0 ir=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; P = 16'h0; B = 8'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Q !== 8'h00 || R !== 8'h00 ||
        dbz !== 1'b0 || ovf !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: got ir=%b ov=%b Q=%h R=%h dbz=%b ovf=%b want ir=1 ov=0 Q=00 R=00 dbz=0 ovf=0",
               in_ready, out_valid, Q, R, dbz, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_req(16'h03E8, 8'h07, 0, 1'b0, "dir_1000_by_7");
    run_req(16'hFE01, 8'hFF, 0, 1'b0, "dir_max_quot");
    run_req(16'hFFFF, 8'hFF, 0, 1'b0, "dir_ovf");
    run_req(16'h1234, 8'h00, 0, 1'b0, "dir_dbz");
    run_req(16'h0000, 8'h01, 0, 1'b0, "dir_zero_div");
    run_req(16'h00FF, 8'h01, 0, 1'b0, "dir_by_one");
    run_req(16'h0100, 8'h01, 0, 1'b0, "dir_ovf_edge");
    run_req(16'h7FFF, 8'h80, 0, 1'b1, "dir_scrambled");
  endtask

  task automatic test_backpressure();
    run_req(16'h03E8, 8'h07, 10, 1'b1, "bp_normal");
    run_req(16'h1234, 8'h00, 10, 1'b1, "bp_dbz");
  endtask

  task automatic test_back_to_back();
    run_req(16'h4D2E, 8'h9B, 0, 1'b0, "b2b_a");
    run_req(16'h0001, 8'hFF, 0, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    in_valid = 1'b1; P = 16'h03E8; B = 8'h07;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Q !== 8'h00 || R !== 8'h00 ||
        dbz !== 1'b0 || ovf !== 1'b0) begin
      nerr++;
      $display("FAIL reset_in_busy: got ir=%b ov=%b Q=%h R=%h dbz=%b ovf=%b want ir=1 ov=0 Q=00 R=00 dbz=0 ovf=0",
               in_ready, out_valid, Q, R, dbz, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nvec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        nerr++; $display("FAIL reset_no_stale cycle %0d: got ir=%b ov=%b want ir=1 ov=0",
                         i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [15:0] p;
    logic [7:0]  b;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: begin b = 8'($urandom); p = {8'($urandom_range(0, b)), 8'($urandom)}; end
        1: begin b = 8'($urandom_range(0, 2)); p = 16'($urandom); end
        default: begin b = 8'($urandom); p = 16'($urandom); end
      endcase
      run_req(p, b, int'($urandom_range(0, 2)), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    test_random(4000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
